// File: rtl/bht_update_queue_pkg.sv
// Shared types and sizing for the BHT update queue.
// bht_update_t mirrors the core's BHT update record.
package bht_update_queue_pkg;

    localparam int unsigned VLEN            = 64;
    localparam int unsigned BHT_UPD_Q_DEPTH = 4;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_q_entry_t;

endpackage

// File: rtl/bht_update_queue.sv
// In-order queue of resolved conditional branches feeding the BHT update port.
// Overflowing pushes are dropped and counted; flush discards everything queued.
module bht_update_queue
    import bht_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = BHT_UPD_Q_DEPTH,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  debug_mode_i,
    input  logic                  resolve_valid_i,
    input  logic                  resolve_is_cond_i,
    input  logic [VLEN-1:0]       resolve_pc_i,
    input  logic                  resolve_taken_i,
    input  logic                  bht_ready_i,
    output bht_update_t           bht_update_o,
    output logic                  full_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned           PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]        PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]        CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};
    localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);

    bht_q_entry_t          mem_r [DEPTH];
    logic [PTR_W:0]        rd_ptr_r;
    logic [PTR_W:0]        wr_ptr_r;
    logic [PTR_W:0]        count_r;
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    logic push_req_s;
    logic pop_s;
    logic push_s;
    logic drop_s;
    logic full_s;
    logic head_valid_s;

    assign full_s       = (count_r == CNT_FULL);
    assign head_valid_s = (count_r != '0) && !flush_i;
    assign push_req_s   = resolve_valid_i && resolve_is_cond_i && !debug_mode_i && !flush_i;
    assign pop_s        = head_valid_s && bht_ready_i;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_s       = push_req_s && (!full_s || pop_s);
    assign drop_s       = push_req_s && full_s && !pop_s;

    // Entry storage; contents need no reset since count_r qualifies them.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= '{pc: resolve_pc_i, taken: resolve_taken_i};
        end
    end

    // Pointers, occupancy and drop counter; reset beats flush beats normal traffic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            drop_cnt_r <= '0;
        end else if (flush_i) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + PTR_ONE;
                2'b01:   count_r <= count_r - PTR_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s && (drop_cnt_r != DROP_MAX)) begin
                drop_cnt_r <= drop_cnt_r + DROP_ONE;
            end
        end
    end

    // Head entry presentation; valid is masked during flush so no pop occurs.
    always_comb begin
        bht_update_o       = '0;
        bht_update_o.valid = head_valid_s;
        bht_update_o.pc    = mem_r[rd_ptr_r[PTR_W-1:0]].pc;
        bht_update_o.taken = mem_r[rd_ptr_r[PTR_W-1:0]].taken;
    end

    assign full_o     = full_s;
    assign drop_cnt_o = drop_cnt_r;

endmodule
